ps2_scancode_decoder: RTL and testbench

Downstream stage of the PS/2 slave receiver. It consumes the receiver's one-cycle `data_valid` strobe and `data_out` byte, strips the `E0` (extended) and `F0` (break) prefixes, and assembles complete key events. Events are buffered in a small FIFO behind a valid/ready interface, so a slow consumer (hex display path, soft-core poll loop) never loses keystrokes unless the buffer overflows.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_evt_fifo.sv | 58 +++++
 rtl/ps2_scancode_decoder.sv | 142 ++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder.
// The prefix timeout is enabled with the PS2_PREFIX_TIMEOUT_EN macro (see ps2_scancode_decoder).
package ps2_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_evt_t;

    localparam int PS2_EVT_W = $bits(ps2_evt_t);

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with registered occupancy count.
// A push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Strips E0/F0 prefixes from PS/2 bytes and queues {code, break, ext} key events.
// Define PS2_PREFIX_TIMEOUT_EN to abandon a dangling prefix after TIMEOUT_CYCLES idle cycles.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            byte_valid,
    input  logic [7:0]                      byte_in,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [7:0]                      evt_code,
    output logic                            evt_break,
    output logic                            evt_ext,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] evt_count,
    output logic                            overflow,
    input  logic                            clr_overflow
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    ps2_state_e state;
    ps2_state_e next_state;
    ps2_evt_t   push_evt;
    ps2_evt_t   head_evt;
    logic       push_req;
    logic       fifo_full;
    logic       fifo_empty;
    logic       timeout;
    logic       is_err;
    logic       is_ext;
    logic       is_brk;

`ifdef PS2_PREFIX_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] to_cnt;

    assign timeout = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (byte_valid || state == S_IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign is_err = (byte_in == PS2_ERR0) || (byte_in == PS2_ERR1);
    assign is_ext = (byte_in == PS2_EXT);
    assign is_brk = (byte_in == PS2_BRK);

    // A byte in the timeout cycle is decoded normally; timeout only acts on idle cycles.
    always_comb begin
        next_state = state;
        push_req   = 1'b0;
        push_evt   = '{code: byte_in, brk: 1'b0, ext: 1'b0};
        if (byte_valid) begin
            case (state)
                S_IDLE: begin
                    if (is_ext)      next_state = S_EXT;
                    else if (is_brk) next_state = S_BRK;
                    else if (!is_err) push_req  = 1'b1;
                end
                S_EXT: begin
                    if (is_brk) begin
                        next_state = S_EXT_BRK;
                    end else if (!is_ext) begin
                        next_state   = S_IDLE;
                        push_req     = !is_err;
                        push_evt.ext = 1'b1;
                    end
                end
                S_BRK: begin
                    if (!is_ext && !is_brk) begin
                        next_state   = S_IDLE;
                        push_req     = !is_err;
                        push_evt.brk = 1'b1;
                    end
                end
                default: begin
                    if (!is_ext && !is_brk) begin
                        next_state   = S_IDLE;
                        push_req     = !is_err;
                        push_evt.brk = 1'b1;
                        push_evt.ext = 1'b1;
                    end
                end
            endcase
        end else if (timeout) begin
            next_state = S_IDLE;
        end
    end

    // When full, a push only fits if the head is popped in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            overflow <= 1'b0;
        end else begin
            state <= next_state;
            if (push_req && fifo_full && !evt_ready) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_EVT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (evt_ready),
        .wdata (push_evt),
        .rdata (head_evt),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (evt_count)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = head_evt.code;
    assign evt_break = head_evt.brk;
    assign evt_ext   = head_evt.ext;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder against a prefix-flag/queue event model.
// Timeout expectations follow PS2_PREFIX_TIMEOUT_EN when it is defined for the build.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       evt_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic [2:0] evt_count;
    logic       overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: pending prefix flags plus a queue of {code, brk, ext}.
    logic [9:0] m_q [$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       m_ovf = 1'b0;
    int         m_to_cnt = 0;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .byte_in      (byte_in),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_break    (evt_break),
        .evt_ext      (evt_ext),
        .evt_count    (evt_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".valid"}, 32'(evt_valid), 32'(m_q.size() != 0));
        checkVal({tag, ".count"}, 32'(evt_count), 32'(m_q.size()));
        checkVal({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
        if (m_q.size() != 0) begin
            checkVal({tag, ".code"}, 32'(evt_code),  32'(m_q[0][9:2]));
            checkVal({tag, ".brk"},  32'(evt_break), 32'(m_q[0][1]));
            checkVal({tag, ".ext"},  32'(evt_ext),   32'(m_q[0][0]));
        end
    endtask

    task automatic applyStimulus(input string tag, input logic v, input logic [7:0] b,
                                 input logic rdy, input logic clr);
        logic produce;
        logic drop;
        logic [9:0] ev;
        byte_valid   = v;
        byte_in      = b;
        evt_ready    = rdy;
        clr_overflow = clr;
        @(posedge clk);
        produce = 1'b0;
        drop    = 1'b0;
        ev      = '0;
`ifdef PS2_PREFIX_TIMEOUT_EN
        if (!v && (m_ext || m_brk)) begin
            if (m_to_cnt == TO - 1) begin
                m_ext    = 1'b0;
                m_brk    = 1'b0;
                m_to_cnt = 0;
            end else begin
                m_to_cnt++;
            end
        end else begin
            m_to_cnt = 0;
        end
`endif
        if (v) begin
            if (b == 8'h00 || b == 8'hFF) begin
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else if (b == 8'hE0) begin
                if (!m_brk) m_ext = 1'b1;
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
                produce = 1'b1;
                ev      = {b, m_brk, m_ext};
                m_ext   = 1'b0;
                m_brk   = 1'b0;
            end
        end
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (produce) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        byte_valid   = 1'b0;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        checkOutput(tag);
    endtask

    task automatic doReset();
        rst          = 1'b0;
        byte_valid   = 1'b0;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        m_q.delete();
        m_ext    = 1'b0;
        m_brk    = 1'b0;
        m_ovf    = 1'b0;
        m_to_cnt = 0;
        @(posedge clk);
        #1;
        checkOutput("reset");
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] seq [5];

        doReset();

        applyStimulus("make", 1'b1, 8'h1C, 1'b0, 1'b0);
        checkVal("make.code_direct", 32'(evt_code), 32'h1C);
        checkVal("make.count_direct", 32'(evt_count), 32'd1);
        applyStimulus("make_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        applyStimulus("xbrk_e0", 1'b1, 8'hE0, 1'b1, 1'b0);
        applyStimulus("xbrk_f0", 1'b1, 8'hF0, 1'b1, 1'b0);
        applyStimulus("xbrk_75", 1'b1, 8'h75, 1'b1, 1'b0);
        checkVal("xbrk.flags_direct", 32'({evt_valid, evt_code, evt_break, evt_ext}), 32'({1'b1, 8'h75, 1'b1, 1'b1}));
        applyStimulus("xbrk_pop", 1'b0, 8'h00, 1'b1, 1'b0);
        checkVal("xbrk.empty_direct", 32'(evt_valid), 32'd0);

        seq = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D};
        foreach (seq[i]) applyStimulus("ovf_fill", 1'b1, seq[i], 1'b0, 1'b0);
        checkVal("ovf.count_direct", 32'(evt_count), 32'd4);
        checkVal("ovf.flag_direct", 32'(overflow), 32'd1);
        checkVal("ovf.head_direct", 32'(evt_code), 32'h15);
        applyStimulus("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        checkVal("ovf.clr_direct", 32'(overflow), 32'd0);

        applyStimulus("full_pushpop", 1'b1, 8'h2C, 1'b1, 1'b0);
        checkVal("full_pushpop.count_direct", 32'(evt_count), 32'd4);
        for (int i = 0; i < 5; i++) applyStimulus("drain", 1'b0, 8'h00, 1'b1, 1'b0);

        applyStimulus("err_f0", 1'b1, 8'hF0, 1'b0, 1'b0);
        applyStimulus("err_ff", 1'b1, 8'hFF, 1'b0, 1'b0);
        applyStimulus("err_1c", 1'b1, 8'h1C, 1'b1, 1'b0);
        checkVal("err.brk_direct", 32'(evt_break), 32'd0);
        applyStimulus("err_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        applyStimulus("rstmid_f0", 1'b1, 8'hF0, 1'b0, 1'b0);
        doReset();
        applyStimulus("rstmid_1c", 1'b1, 8'h1C, 1'b0, 1'b0);
        applyStimulus("rstmid_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        applyStimulus("to_f0", 1'b1, 8'hF0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus("to_wait", 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus("to_1c", 1'b1, 8'h1C, 1'b0, 1'b0);
`ifdef PS2_PREFIX_TIMEOUT_EN
        checkVal("to.brk_direct", 32'(evt_break), 32'd0);
`else
        checkVal("to.brk_direct", 32'(evt_break), 32'd1);
`endif
        applyStimulus("to_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       rb = 8'hE0;
                1:       rb = 8'hF0;
                2:       rb = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                3:       rb = 8'hE1;
                default: rb = 8'($urandom_range(1, 254));
            endcase
            applyStimulus("rand", 1'($urandom_range(0, 1)), rb,
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
